// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch (0) and load/store (1) with timeout abort
module mem_port_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mux_control,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state;
  logic last_grant;
  logic [CW-1:0] cnt;
  logic e0, e1, win, timed_out;
  // a requester is ignored in its own done cycle so a held req cannot re-win immediately
  always_comb begin
    e0 = req0 & ~done0;
    e1 = req1 & ~done1;
    win = (e0 & e1) ? ~last_grant : e1;
    timed_out = (TIMEOUT != 0) && (cnt == LAST);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      cnt <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      mux_control <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
    end else if (state == IDLE) begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (e0 | e1) begin
        state <= BUSY;
        mux_control <= win;
        gnt0 <= ~win;
        gnt1 <= win;
        mem_req <= 1'b1;
        mem_addr <= win ? addr1 : addr0;
        mem_wdata <= win ? wdata1 : wdata0;
        mem_we <= win ? we1 : we0;
        cnt <= '0;
      end
    end else if (mem_ready || timed_out) begin
      // mem_ready takes priority; otherwise this is a timeout abort
      state <= IDLE;
      mem_req <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= ~mux_control;
      done1 <= mux_control;
      err0 <= ~mem_ready & ~mux_control;
      err1 <= ~mem_ready & mux_control;
      last_grant <= mux_control;
      if (!mux_control) rdata0 <= !mem_ready ? ERR_DATA : mem_we ? rdata0 : mem_rdata;
      if (mux_control) rdata1 <= !mem_ready ? ERR_DATA : mem_we ? rdata1 : mem_rdata;
    end else if (TIMEOUT != 0) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench, TIMEOUT reduced to 4
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, mem_ready = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic gnt0, gnt1, done0, done1, err0, err1, mux_control, mem_req, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mux_control(mux_control), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, mux_control, mem_req, mem_we} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000000", {gnt0, gnt1, done0, done1, err0, err1, mux_control, mem_req, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata0, rdata1} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h want all 0", mem_addr, mem_wdata, rdata0, rdata1);
    end
  endtask

  task automatic test_single_read();
    req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1, mem_req, mux_control, mem_we} !== 5'b10100 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL read_grant: gnt0/gnt1/req/mux/we=%b addr=%h want 10100 addr=00000100", {gnt0, gnt1, mem_req, mux_control, mem_we}, mem_addr);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL read_busy2: gnt0=%b done0=%b want 1 0", gnt0, done0);
    end
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0; req0 = 1'b0;
    checks++;
    if ({done0, done1, err0, gnt0, mem_req} !== 5'b10000 || rdata0 !== 32'h1234_5678 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL read_done: done0/done1/err0/gnt0/req=%b rd0=%h rd1=%h want 10000 12345678 00000000", {done0, done1, err0, gnt0, mem_req}, rdata0, rdata1);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || rdata0 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_after: done0=%b rd0=%h want 0 12345678", done0, rdata0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order;
    logic [3:0] muxes;
    int n;
    logic pg0, pg1;
    do_reset();
    n = 0; pg0 = 1'b0; pg1 = 1'b0; order = '0; muxes = '0;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0A0A; we0 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 14 && n < 4; i++) begin
      tick();
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("FAIL rr_both_gnt: gnt0=%b gnt1=%b want not both", gnt0, gnt1);
      end
      if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
        order[n] = gnt1;
        muxes[n] = mux_control;
        n++;
      end
      pg0 = gnt0; pg1 = gnt1;
      req0 = !done0; req1 = !done1;
      if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    checks++;
    if (n != 4 || order !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order: grants=%0d order(lsb first)=%b want 4 1010", n, order);
    end
    checks++;
    if (muxes !== 4'b1010) begin
      errors++;
      $display("FAIL rr_mux: mux(lsb first)=%b want 1010", muxes);
    end
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (rdata0 !== 32'h0000_0A0A || rdata1 !== 32'h0000_0A0A || gnt0 || gnt1) begin
      errors++;
      $display("FAIL rr_end: rd0=%h rd1=%h gnt=%b%b want 00000a0a 00000a0a 00", rdata0, rdata1, gnt0, gnt1);
    end
  endtask

  task automatic test_write_port1();
    req1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hCAFE_F00D; we1 = 1'b1;
    tick();
    checks++;
    if ({gnt1, gnt0, mux_control, mem_we, mem_req} !== 5'b10111 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL wr_grant: gnt1/gnt0/mux/we/req=%b wdata=%h addr=%h want 10111 cafef00d 00000040", {gnt1, gnt0, mux_control, mem_we, mem_req}, mem_wdata, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ready = 1'b0; req1 = 1'b0; we1 = 1'b0;
    checks++;
    if ({done1, done0, err1} !== 3'b100 || rdata1 !== 32'h0000_0A0A) begin
      errors++;
      $display("FAIL wr_done: done1/done0/err1=%b rd1=%h want 100 00000a0a", {done1, done0, err1}, rdata1);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    req0 = 1'b1; addr0 = 32'h200; we0 = 1'b1; wdata0 = 32'h0F0F_0F0F;
    mem_ready = 1'b0;
    tick();
    n = 0;
    while (gnt0 && n < 10) begin
      n++;
      tick();
    end
    req0 = 1'b0; we0 = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL to_busy_cycles: got %0d want 4", n);
    end
    checks++;
    if ({done0, err0, done1, err1, mem_req} !== 5'b11000 || rdata0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL to_abort: done0/err0/done1/err1/req=%b rd0=%h want 11000 deadbeef", {done0, err0, done1, err1, mem_req}, rdata0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: done0=%b err0=%b want 0 0", done0, err0);
    end
    req0 = 1'b1; addr0 = 32'h300;
    tick();
    tick();
    tick();
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h7777_0004; req0 = 1'b0;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({done0, err0} !== 2'b10 || rdata0 !== 32'h7777_0004) begin
      errors++;
      $display("FAIL to_last_cycle: done0/err0=%b rd0=%h want 10 77770004", {done0, err0}, rdata0);
    end
    tick();
  endtask

  task automatic test_disturbance();
    req0 = 1'b1; addr0 = 32'h500; we0 = 1'b0;
    tick();
    req0 = 1'b0; addr0 = 32'h999;
    tick();
    checks++;
    if (mem_addr !== 32'h500 || gnt0 !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL dist_hold: addr=%h gnt0=%b req=%b want 00000500 1 1", mem_addr, gnt0, mem_req);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_1111;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (done0 !== 1'b1 || rdata0 !== 32'h0000_1111 || mem_addr !== 32'h500) begin
      errors++;
      $display("FAIL dist_done: done0=%b rd0=%h addr=%h want 1 00001111 00000500", done0, rdata0, mem_addr);
    end
    tick();
  endtask

  task automatic test_reset_in_busy();
    req0 = 1'b1; addr0 = 32'h600;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req0 = 1'b0;
    checks++;
    if ({mem_req, gnt0, gnt1, done0, done1} !== 5'b0 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy: req/gnt0/gnt1/done0/done1=%b rd0=%h want 00000 00000000", {mem_req, gnt0, gnt1, done0, done1}, rdata0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: done0=%b req=%b want 0 0", done0, mem_req);
    end
    req0 = 1'b1; req1 = 1'b1; addr1 = 32'h700;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if ({gnt0, gnt1, mux_control} !== 3'b100 || mem_addr !== 32'h600) begin
      errors++;
      $display("FAIL rst_first_tie: gnt0/gnt1/mux=%b addr=%h want 100 00000600", {gnt0, gnt1, mux_control}, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_port1();
    test_timeout();
    test_disturbance();
    test_reset_in_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Round-robin arbitration, one outstanding transaction at a time.
- Drives the select of the downstream 2:1 address/data mux (mux_control) and latches each request so the memory sees stable inputs.
- Per-transaction timeout guards against a hung memory.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for mem_ready before abort; 0 disables timeout.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout abort.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / port 1; held high until done.
- addr0 / addr1  in  32  request address.
- wdata0 / wdata1  in  32  write data.
- we0 / we1  in  1  1 = write, 0 = read.
- gnt0 / gnt1  out  1  high while that port's transaction is in progress (BUSY).
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read data, valid when done is high, held afterwards.
- err0 / err1  out  1  one-cycle pulse with done on timeout abort.
- mux_control  out  1  0 = port 0 owns the memory path, 1 = port 1.
- mem_req  out  1  request to memory.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_we  out  1  latched write enable.
- mem_ready  in  1  memory completion, sampled only in BUSY.
- mem_rdata  in  32  memory read data, valid with mem_ready.

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state including mid-transaction):
  - state = IDLE; gnt*, done*, err*, mem_req, mem_we = 0; mem_addr, mem_wdata, rdata* = 0; mux_control = 0; timeout counter = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - An in-flight memory access is abandoned; mem_req drops on the reset edge.
- States: IDLE, BUSY.
- IDLE:
  - Eligible port: req high and its done not high in the same cycle. This masks the requester's release cycle.
  - One eligible port: it wins.
  - Both eligible: the port other than last_grant wins.
  - On a win, at the next edge: state = BUSY; mux_control = winner; gnt_winner = 1; mem_req = 1; mem_addr, mem_wdata, mem_we latched from the winner's inputs; counter = 0.
  - No eligible port: stay in IDLE, outputs unchanged except done/err, which clear.
- BUSY:
  - Latched mem_* values and mux_control are held constant. Requester input changes are ignored, including req dropping; the transaction always completes.
  - mem_ready = 1: next edge → IDLE; mem_req = 0; gnt = 0; done_winner = 1 for one cycle; rdata_winner = mem_rdata on a read, unchanged on a write; last_grant = winner.
  - mem_ready = 0 and TIMEOUT ≠ 0: counter increments. When counter == TIMEOUT-1 and mem_ready is still 0, the next edge aborts:
    - → IDLE; mem_req = 0; done_winner = 1; err_winner = 1; rdata_winner = ERR_DATA, even on a write; last_grant = winner.
  - mem_ready wins over timeout in the same cycle.
- Latency: req seen in IDLE at cycle t → mem_req at t+1. With mem_ready at t+k (k ≥ 1), done at t+k+1.
- Minimum spacing between consecutive grants: 2 cycles, because there is one IDLE cycle between transactions.
- The non-winning port is never starved: with both requesting continuously, grants alternate 0,1,0,1.
- done and err are never high on both ports in the same cycle; gnt0 and gnt1 are never both high.

Test Plan:
- Single read: reset, then req0 = 1, addr0 = 0x100, we0 = 0; memory returns mem_ready at the 2nd BUSY cycle with 0x1234_5678 → mux_control = 0, mem_addr = 0x100, gnt0 high 2 cycles, done0 pulse, rdata0 = 0x1234_5678, rdata1 unchanged at 0.
- Simultaneous requests after reset, memory answering in 1 cycle, both reqs held high across 4 transactions (each port drops req only in its done cycle, then re-raises) → grant order 0,1,0,1; mux_control toggles each time; no back-to-back same-port grant.
- Write by port 1: addr1 = 0x40, wdata1 = 0xCAFE_F00D, we1 = 1 → mem_we = 1, mem_wdata = 0xCAFE_F00D, mux_control = 1; on done1, rdata1 unchanged.
- Timeout with TIMEOUT = 4: mem_ready held 0 → exactly 4 BUSY cycles, then done0 = err0 = 1 for one cycle, rdata0 = 0xDEAD_BEEF, mem_req low. Separately, mem_ready arriving in the 4th BUSY cycle → normal completion, err0 = 0.
- Input disturbance: req0 dropped and addr0 changed mid-BUSY → mem_addr stays latched; done0 still pulses.
- Reset in BUSY: reset asserted at the 2nd BUSY cycle → next cycle mem_req = 0, gnt = 0, no done pulse; after reset, simultaneous reqs → port 0 granted first.
